// File: rtl/map_writer.sv
// map_writer: shadow tile map with vblank-synchronised publish and a border-wall clear sweep.
// Optional MAP_WRITER_PREV_TILE_EN adds a previous-tile response for every in-range write.
package map_pkg;
    localparam int MAP_HEIGHT = 10;
    localparam int MAP_WIDTH = 12;
    typedef enum logic [2:0] {EMPTY, WALL, SNAKE1, SNAKE2, POINT} tile_t;
    typedef struct packed {
        tile_t [MAP_HEIGHT-1:0][MAP_WIDTH-1:0] tiles;
    } map_s;
endpackage

module map_writer
    import map_pkg::*;
#(
    parameter int ROW_W = $clog2(MAP_HEIGHT),
    parameter int COL_W = $clog2(MAP_WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             vblnk,
    input  logic             clear_req,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [ROW_W-1:0] wr_row,
    input  logic [COL_W-1:0] wr_col,
    input  tile_t            wr_tile,
    output logic             wr_err,
    output map_s             map_o,
    output logic             frame_done,
    output logic             busy,
    output logic             resp_valid,
    output tile_t            prev_tile
);
    typedef enum logic {CLEAR, IDLE} state_t;

    state_t           state_q, state_d;
    logic [ROW_W-1:0] row_q, row_d;
    map_s             shadow_q, shadow_d, map_q, map_d;
    logic             commit_pending_q, commit_pending_d;
    logic             vblnk_q;
    logic             wr_err_q, wr_err_d;
    logic             frame_done_q, frame_done_d;
    logic             vb_edge, accept, in_range, publish, last_row;

    always_comb begin
        vb_edge = vblnk & ~vblnk_q;
        wr_ready = (state_q == IDLE) && !clear_req;
        accept = wr_valid && wr_ready;
        in_range = ({1'b0, wr_row} < (ROW_W+1)'(MAP_HEIGHT)) && ({1'b0, wr_col} < (COL_W+1)'(MAP_WIDTH));
        publish = (state_q == IDLE) && (vb_edge || commit_pending_q);
        last_row = row_q == ROW_W'(MAP_HEIGHT-1);
        state_d = state_q;
        row_d = row_q;
        shadow_d = shadow_q;
        map_d = publish ? shadow_q : map_q;
        commit_pending_d = commit_pending_q && !publish;
        wr_err_d = accept && !in_range;
        frame_done_d = publish;
        if (state_q == CLEAR) begin
            for (int c = 0; c < MAP_WIDTH; c++)
                shadow_d.tiles[row_q][c] = (row_q == '0 || last_row || c == 0 || c == MAP_WIDTH-1) ? WALL : EMPTY;
            row_d = last_row ? '0 : row_q + 1'b1;
            state_d = last_row ? IDLE : CLEAR;
            if (vb_edge) commit_pending_d = 1'b1;
        end else if (clear_req) begin
            state_d = CLEAR;
            row_d = '0;
            commit_pending_d = 1'b1;
        end
        // publish above samples shadow_q, so a write in the publish cycle waits for the next frame
        if (accept && in_range) shadow_d.tiles[wr_row][wr_col] = wr_tile;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            row_q <= '0;
            shadow_q <= '0;
            map_q <= '0;
            commit_pending_q <= 1'b1;
            vblnk_q <= 1'b0;
            wr_err_q <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q <= state_d;
            row_q <= row_d;
            shadow_q <= shadow_d;
            map_q <= map_d;
            commit_pending_q <= commit_pending_d;
            vblnk_q <= vblnk;
            wr_err_q <= wr_err_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign map_o = map_q;
    assign wr_err = wr_err_q;
    assign frame_done = frame_done_q;
    assign busy = state_q == CLEAR;

`ifdef MAP_WRITER_PREV_TILE_EN
    logic  resp_valid_q, resp_valid_d;
    tile_t prev_tile_q, prev_tile_d;

    always_comb begin
        resp_valid_d = accept && in_range;
        prev_tile_d = in_range ? shadow_q.tiles[wr_row][wr_col] : EMPTY;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= 1'b0;
            prev_tile_q <= EMPTY;
        end else begin
            resp_valid_q <= resp_valid_d;
            prev_tile_q <= prev_tile_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign prev_tile = prev_tile_q;
`else
    assign resp_valid = 1'b0;
    assign prev_tile = EMPTY;
`endif
endmodule

// File: tb/tb_map_writer.sv
// tb_map_writer: table-driven writes plus clear/publish/reset sequences, with a scoreboard of
// expected pulses (wr_err, resp_valid/prev_tile, frame_done with published map) checked every cycle.
module tb_map_writer;
    import map_pkg::*;
    localparam int H = MAP_HEIGHT;
    localparam int W = MAP_WIDTH;
    localparam int RW = $clog2(H);
    localparam int CW = $clog2(W);

    logic clk = 0, rst = 1, vblnk = 0, clear_req = 0, wr_valid = 0;
    logic wr_ready, wr_err, frame_done, busy, resp_valid;
    logic [RW-1:0] wr_row = '0;
    logic [CW-1:0] wr_col = '0;
    tile_t wr_tile = EMPTY, prev_tile;
    map_s map_o;

    int total = 0, bad = 0, cyc = 0;
    bit mon_en = 0;

    typedef struct {
        int    due;
        int    kind;
        tile_t tile;
        map_s  map;
    } ev_t;
    ev_t sb[$];

    typedef struct {
        int    r;
        int    c;
        tile_t t;
    } vec_t;
    vec_t tv[8];

    map_s mdl, cleared;
    bit xe, xr, xf;
    tile_t xt;
    map_s xm;

    map_writer dut (
        .clk(clk), .rst(rst), .vblnk(vblnk), .clear_req(clear_req),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_row(wr_row), .wr_col(wr_col),
        .wr_tile(wr_tile), .wr_err(wr_err), .map_o(map_o), .frame_done(frame_done),
        .busy(busy), .resp_valid(resp_valid), .prev_tile(prev_tile)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%0d want=%0d (cycle %0d)", name, got, want, cyc);
        end
    endtask

    task automatic chk_map(input string name, input map_s got, input map_s want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", name, got, want);
        end
    endtask

    function automatic map_s clear_map();
        map_s m;
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                m.tiles[r][c] = (r == 0 || r == H-1 || c == 0 || c == W-1) ? WALL : EMPTY;
        return m;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int kind, input tile_t t, input map_s m, input int due);
        ev_t e;
        e.due = due;
        e.kind = kind;
        e.tile = t;
        e.map = m;
        sb.push_back(e);
    endtask

    task automatic wr(input int r, input int c, input tile_t t);
        wr_valid = 1;
        wr_row = RW'(r);
        wr_col = CW'(c);
        wr_tile = t;
        #1;
        chk("wr_ready", wr_ready, 1);
        if (r < H && c < W) begin
`ifdef MAP_WRITER_PREV_TILE_EN
            push(1, mdl.tiles[r][c], '0, cyc + 1);
`endif
            mdl.tiles[r][c] = t;
        end else push(0, EMPTY, '0, cyc + 1);
        step();
        wr_valid = 0;
    endtask

    always @(negedge clk) if (mon_en) begin
        xe = 0;
        xr = 0;
        xf = 0;
        xt = EMPTY;
        xm = '0;
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].due == cyc) begin
                if (sb[i].kind == 0) xe = 1;
                else if (sb[i].kind == 1) begin
                    xr = 1;
                    xt = sb[i].tile;
                end else begin
                    xf = 1;
                    xm = sb[i].map;
                end
                sb.delete(i);
            end else if (sb[i].due < cyc) begin
                total++;
                bad++;
                $display("FAIL missed event: kind=%0d due=%0d now=%0d", sb[i].kind, sb[i].due, cyc);
                sb.delete(i);
            end
        end
        chk("wr_err", wr_err, xe);
        chk("resp_valid", resp_valid, xr);
        chk("frame_done", frame_done, xf);
        if (xr) chk("prev_tile", prev_tile, xt);
`ifndef MAP_WRITER_PREV_TILE_EN
        chk("prev_tile const", prev_tile, EMPTY);
`endif
        if (xf) chk_map("published map", map_o, xm);
    end

    initial begin
        tv = '{'{3, 7, SNAKE1}, '{1, 1, SNAKE2}, '{8, 10, POINT}, '{0, 0, EMPTY},
               '{H, 0, WALL}, '{2, W, WALL}, '{H-1, W-1, SNAKE1}, '{15, 15, POINT}};
        mdl = '0;
        cleared = clear_map();

        // reset with a write held valid: accepted only once the sweep is done
        rst = 1;
        wr_valid = 1;
        wr_row = 1;
        wr_col = 1;
        wr_tile = EMPTY;
        step();
        step();
        mon_en = 1;
        rst = 0;
        #1;
        chk_map("reset map_o", map_o, '0);
        chk("reset busy", busy, 1);
        mdl = cleared;
        push(2, EMPTY, cleared, cyc + H + 1);
        for (int k = 0; k < H; k++) begin
            chk("ready low in clear", wr_ready, 0);
            chk("busy in clear", busy, 1);
            step();
        end
        chk("ready after clear", wr_ready, 1);
        chk("busy after clear", busy, 0);
`ifdef MAP_WRITER_PREV_TILE_EN
        push(1, EMPTY, '0, cyc + 1);
`endif
        step();
        wr_valid = 0;
        step();
        chk("border top", map_o.tiles[0][4], WALL);
        chk("border left", map_o.tiles[6][0], WALL);
        chk("border right", map_o.tiles[6][W-1], WALL);
        chk("border bottom", map_o.tiles[H-1][3], WALL);
        chk("interior 5,5", map_o.tiles[5][5], EMPTY);

        // table of writes, including out-of-range rows/cols, then a vblank publish
        for (int i = 0; i < 8; i++) wr(tv[i].r, tv[i].c, tv[i].t);
        step();
        chk("unpublished 3,7", map_o.tiles[3][7], EMPTY);
        vblnk = 1;
        push(2, EMPTY, mdl, cyc + 1);
        step();
        chk("published 3,7", map_o.tiles[3][7], SNAKE1);
        step();
        step();
        vblnk = 0;
        step();

        // write coinciding with the vblank edge lands in the next frame
        vblnk = 1;
        push(2, EMPTY, mdl, cyc + 1);
        wr(4, 4, POINT);
        chk("same-cycle write held back", map_o.tiles[4][4], EMPTY);
        step();
        vblnk = 0;
        step();
        vblnk = 1;
        push(2, EMPTY, mdl, cyc + 1);
        step();
        chk("write published next frame", map_o.tiles[4][4], POINT);
        vblnk = 0;
        step();

        // back-to-back writes to the same tile
        wr(2, 2, POINT);
        wr(2, 2, SNAKE2);
        step();

        // clear_req beats a write; vblank edge mid-clear defers the publish
        clear_req = 1;
        wr_valid = 1;
        wr_row = 2;
        wr_col = 3;
        wr_tile = WALL;
        #1;
        chk("ready with clear_req", wr_ready, 0);
        mdl = cleared;
        push(2, EMPTY, cleared, cyc + H + 2);
        step();
        clear_req = 0;
        wr_valid = 0;
        for (int k = 0; k < H; k++) begin
            chk("busy in re-clear", busy, 1);
            if (k == 3) vblnk = 1;
            if (k == 5) clear_req = 1;
            if (k == 6) clear_req = 0;
            step();
        end
        chk("busy after re-clear", busy, 0);
        step();
        vblnk = 0;
        step();

        // reset during an out-of-range write and again mid-clear
        wr_valid = 1;
        wr_row = RW'(H);
        wr_col = 0;
        wr_tile = WALL;
        rst = 1;
        step();
        wr_valid = 0;
        rst = 0;
        step();
        step();
        rst = 1;
        step();
        rst = 0;
        chk_map("map_o after reset", map_o, '0);
        mdl = cleared;
        push(2, EMPTY, cleared, cyc + H + 1);
        for (int k = 0; k < H + 3; k++) step();

        chk("scoreboard drained", sb.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
